msg_stream_sched: RTL and testbench
===================================

# msg_stream_sched

Sequencer and round-robin arbiter for the character-message datapath. It grants one of NUM_REQ requesters at a time and latches that requester's 2-bit message select. It then streams the selected ASCII message one byte per accepted beat over a valid/ready interface, and pulses a per-requester done. It sits between the control logic that wants text emitted and the 8-bit character output path.

## Interface
- NUM_REQ, 2: number of requesters (2..4).
- LEN_W, 4: width of the beat index; must hold max message length − 1 (8).
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clock clk.
- req  in  NUM_REQ  level request per requester.
- msg_sel  in  2*NUM_REQ  message select per requester; requester i uses bits [2i+1:2i].
- grant  out  NUM_REQ  one-hot, high for the whole transfer of the owner.
- done  out  NUM_REQ  one-cycle pulse to the owner after its last beat is accepted.
- char_data  out  8  current ASCII byte.
- char_valid  out  1  char_data is valid.
- char_ready  in  1  sink accepts the beat when char_valid && char_ready.
- char_last  out  1  high with the final beat of a message.
- busy  out  1  high in STREAM and DONE.

## Operation
- Message map:
  - msg_sel 00 or 11 → "Guatemala", 9 beats: 47 75 61 74 65 6D 61 6C 61.
  - msg_sel 01 or 10 → "QQuetza", 7 beats: 51 51 75 65 74 7A 61.
- FSM states are IDLE, STREAM and DONE.
  - IDLE: all outputs 0. If any req bit is high, the round-robin pick is made, starting at (last_owner+1) mod NUM_REQ. On that edge the block registers the owner, latches that owner's msg_sel, clears idx to 0, sets grant, and moves to STREAM.
  - STREAM: char_valid=1. char_data=rom(msg, idx). char_last=(idx==len−1).
    - On an accepted beat that is not last: idx increments.
    - On an accepted last beat: the block moves to DONE and sets last_owner to the current owner.
  - DONE: grant=0, char_valid=0, done[owner]=1 for exactly one cycle, then the block returns to IDLE.
- Once granted, a transfer always completes; there is no abort.
  - A req drop during STREAM is ignored.
  - A msg_sel change during STREAM is ignored, because the select was latched at grant.
- While char_ready=0, char_data, char_last and idx hold stable and char_valid stays high.
- A requester that still holds req after its done competes again in the next IDLE. If only one requester is asking, it wins back-to-back.
- Reset value of every output is 0. State resets to IDLE, idx to 0, and last_owner to NUM_REQ−1, so requester 0 has first priority.
- Reset mid-stream clears all outputs immediately, without waiting for a clock edge. No done is issued for the aborted message.

## Timing
- Every output is decoded from registers only. There is no combinational path from req, msg_sel or char_ready to any output.
- Grant latency: req sampled high at edge k gives grant and char_valid high after edge k.
- With char_ready held 1, a message takes L beat cycles, then 1 DONE cycle, then 1 IDLE cycle. A new grant therefore comes L+2 cycles after the previous first beat.
- idx is unsigned LEN_W bits and never exceeds len−1, so no wrap is possible.

## Structure
- Package msg_stream_pkg holds:
  - state enum (IDLE, STREAM, DONE);
  - message ID constants MSG_GUATEMALA and MSG_QQUETZA;
  - their lengths, 9 and 7;
  - the select-to-ID decode function.
- One combinational sub-module, msg_rom, with inputs msg ID and idx and outputs byte and len. Bytes are returned as 00 beyond len.
- Round-robin pick is a function in the package.

## Test plan
- Single requester: req[0] with sel 00 and char_ready=1.
  - Expect grant[0] next cycle, then beats 47 75 61 74 65 6D 61 6C 61 on consecutive cycles.
  - Expect char_last only on the 9th beat and done[0] on the following cycle.
- Contention: both req high after reset with sel0=01 and sel1=00, held throughout.
  - Expect order: requester 0 with "QQuetza" (7 beats), then requester 1 with "Guatemala", then requester 0 again.
- Backpressure: char_ready high only one cycle in three.
  - Expect char_data and char_last stable during stalls, the same byte sequence, and done only after the last accept.
- Mid-stream changes: drop req and change msg_sel at beat 3.
  - Expect the original message to complete unchanged, with done asserted.
- Reset at beat 4.
  - Expect all outputs 0 asynchronously and no done.
  - After release with req[1] high, expect grant[1] and a stream restarting from idx 0.
- Select aliasing: sel 11 → "Guatemala", sel 10 → "QQuetza", each with correct length and char_last position.

Source files
------------

// File: rtl/msg_stream_sched_pkg.sv
// msg_stream_pkg: shared types, message IDs/lengths, select decode and round-robin pick
package msg_stream_pkg;
   typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
   typedef logic msg_t;
   localparam msg_t MSG_GUATEMALA = 1'b0;
   localparam msg_t MSG_QQUETZA = 1'b1;
   localparam int LEN_GUATEMALA = 9;
   localparam int LEN_QQUETZA = 7;
   function automatic msg_t msg_decode(input logic [1:0] sel);
      return (sel[1] ^ sel[0]) ? MSG_QQUETZA : MSG_GUATEMALA;
   endfunction
   // Scans farthest-first so the nearest requester after last ends up winning.
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last, input int n);
      logic [1:0] pick;
      pick = last;
      for (int i = n; i >= 1; i--) begin
         int c;
         c = (int'(last) + i) % n;
         if (req[c]) pick = 2'(c);
      end
      return pick;
   endfunction
endpackage

// File: rtl/msg_stream_sched_if.sv
// msg_stream_sched_if: request/grant and character stream signals of the sequencer
interface msg_stream_sched_if #(parameter int NUM_REQ = 2);
   logic [NUM_REQ-1:0] req;
   logic [2*NUM_REQ-1:0] msg_sel;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] done;
   logic [7:0] char_data;
   logic char_valid;
   logic char_ready;
   logic char_last;
   logic busy;
   modport master (input req, msg_sel, char_ready, output grant, done, char_data, char_valid, char_last, busy);
   modport slave (output req, msg_sel, char_ready, input grant, done, char_data, char_valid, char_last, busy);
endinterface

// File: rtl/msg_stream_sched_rom.sv
// msg_rom: byte and length lookup for the two fixed messages, zero beyond the length
module msg_rom
   import msg_stream_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  msg_t             msg,
   input  logic [LEN_W-1:0] idx,
   output logic [7:0]       data,
   output logic [LEN_W-1:0] len
);
   localparam logic [7:0] GUAT [16] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C,
                                        8'h61, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   localparam logic [7:0] QQ [16] = '{8'h51, 8'h51, 8'h75, 8'h65, 8'h74, 8'h7A, 8'h61, 8'h00,
                                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   always_comb begin
      len = (msg == MSG_QQUETZA) ? LEN_W'(LEN_QQUETZA) : LEN_W'(LEN_GUATEMALA);
      data = (idx >= len) ? 8'h00 : (msg == MSG_QQUETZA) ? QQ[4'(idx)] : GUAT[4'(idx)];
   end
endmodule

// File: rtl/msg_stream_sched.sv
// msg_stream_sched: round-robin grant of one requester, then streams its message byte by byte
module msg_stream_sched
   import msg_stream_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int LEN_W = 4
) (
   input logic             clk,
   input logic             reset,
   msg_stream_sched_if.master bus
);
   state_t state;
   msg_t msg;
   logic [LEN_W-1:0] idx, len;
   logic [7:0] rom_data;
   logic [1:0] owner, last_owner, pick;
   logic [NUM_REQ-1:0] grant, done;
   logic valid, busy, last;
   msg_rom #(.LEN_W(LEN_W)) u_rom (.msg(msg), .idx(idx), .data(rom_data), .len(len));
   assign pick = rr_pick(4'(bus.req), last_owner, NUM_REQ);
   assign last = (idx == len - LEN_W'(1));
   // Data and last are gated by valid so an async reset zeroes them with the registers.
   assign bus.char_valid = valid;
   assign bus.char_data = valid ? rom_data : 8'h00;
   assign bus.char_last = valid && last;
   assign bus.grant = grant;
   assign bus.done = done;
   assign bus.busy = busy;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         msg <= MSG_GUATEMALA;
         idx <= '0;
         owner <= '0;
         last_owner <= 2'(NUM_REQ - 1);
         grant <= '0;
         done <= '0;
         valid <= 1'b0;
         busy <= 1'b0;
      end else begin
         case (state)
            IDLE: if (|bus.req) begin
               owner <= pick;
               msg <= msg_decode(bus.msg_sel[2*pick +: 2]);
               idx <= '0;
               grant <= NUM_REQ'(1) << pick;
               valid <= 1'b1;
               busy <= 1'b1;
               state <= STREAM;
            end
            STREAM: if (bus.char_ready) begin
               if (last) begin
                  state <= DONE;
                  last_owner <= owner;
                  grant <= '0;
                  valid <= 1'b0;
                  done <= NUM_REQ'(1) << owner;
               end else begin
                  idx <= idx + LEN_W'(1);
               end
            end
            DONE: begin
               done <= '0;
               busy <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_msg_stream_sched.sv
// tb_msg_stream_sched: directed and random transfers checked against a message-string model
module tb_msg_stream_sched;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   int last_m = 1;
   msg_stream_sched_if #(.NUM_REQ(2)) bus ();
   msg_stream_sched #(.NUM_REQ(2), .LEN_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_grant"}, 32'(bus.grant), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_valid"}, 32'(bus.char_valid), 0);
      check({tag, "_data"}, 32'(bus.char_data), 0);
      check({tag, "_last"}, 32'(bus.char_last), 0);
      check({tag, "_busy"}, 32'(bus.busy), 0);
   endtask

   function automatic int rr_model(input logic [1:0] r, input int last);
      for (int k = 1; k <= 2; k++)
         if (r[(last + k) % 2]) return (last + k) % 2;
      return last;
   endfunction

   // mode: 0 ready always, 1 ready one cycle in three, 2 random ready
   task automatic transfer(input int mode, input int change_at, input int abort_at);
      int own, len, idx, cyc;
      string m;
      logic [1:0] sel;
      bit rdy;
      own = rr_model(bus.req, last_m);
      sel = bus.msg_sel[2*own +: 2];
      m = (sel == 2'b01 || sel == 2'b10) ? "QQuetza" : "Guatemala";
      len = m.len();
      @(posedge clk);
      @(negedge clk);
      check("grant", 32'(bus.grant), 32'(1 << own));
      check("busy", 32'(bus.busy), 1);
      idx = 0;
      cyc = 0;
      while (idx < len && cyc < 200) begin
         check("valid", 32'(bus.char_valid), 1);
         check("data", 32'(bus.char_data), 32'(m[idx]));
         check("last", 32'(bus.char_last), 32'(idx == len - 1));
         check("done_early", 32'(bus.done), 0);
         check("grant_hold", 32'(bus.grant), 32'(1 << own));
         if (idx == abort_at) begin
            #2 reset = 1'b1;
            #1 check_quiet("async_rst");
            @(negedge clk);
            check_quiet("rst_hold");
            reset = 1'b0;
            last_m = 1;
            return;
         end
         if (idx == change_at) begin
            bus.req = '0;
            bus.msg_sel = ~bus.msg_sel;
            change_at = -1;
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 2) : 1'($urandom_range(1, 0));
         bus.char_ready = rdy;
         @(negedge clk);
         if (rdy) idx++;
         cyc++;
      end
      check("beats_accepted", 32'(idx), 32'(len));
      check("done", 32'(bus.done), 32'(1 << own));
      check("grant_off", 32'(bus.grant), 0);
      check("valid_off", 32'(bus.char_valid), 0);
      check("busy_done", 32'(bus.busy), 1);
      last_m = own;
      @(negedge clk);
      check("idle_done", 32'(bus.done), 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_grant", 32'(bus.grant), 0);
   endtask

   initial begin
      bus.req = '0;
      bus.msg_sel = '0;
      bus.char_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_quiet("reset");
      reset = 1'b0;
      bus.req = 2'b01;
      bus.msg_sel = 4'b0000;
      transfer(0, -1, -1);
      bus.req = '0;
      @(negedge clk);
      check_quiet("no_req");
      bus.req = 2'b11;
      bus.msg_sel = 4'b0001;
      transfer(0, -1, -1);
      transfer(0, -1, -1);
      transfer(0, -1, -1);
      bus.req = 2'b01;
      bus.msg_sel = 4'b0000;
      transfer(1, -1, -1);
      bus.req = 2'b01;
      bus.msg_sel = 4'b0000;
      transfer(0, 3, -1);
      @(negedge clk);
      check_quiet("after_drop");
      bus.req = 2'b01;
      bus.msg_sel = 4'b0000;
      transfer(0, -1, 4);
      bus.req = 2'b10;
      bus.msg_sel = 4'b0000;
      transfer(0, -1, -1);
      bus.req = 2'b01;
      bus.msg_sel = 4'b0011;
      transfer(0, -1, -1);
      bus.req = 2'b10;
      bus.msg_sel = 4'b1000;
      transfer(0, -1, -1);
      for (int i = 0; i < 8; i++) begin
         bus.req = 2'($urandom_range(3, 1));
         bus.msg_sel = 4'($urandom);
         transfer(2, -1, -1);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
